pwm_duty_sequencer: RTL and testbench
=====================================

// Module: pwm_duty_sequencer
// PURPOSE
//  Controls the duty input of the PWM signal generator. Two requesters share it:
//  A (manual/safety, high priority) and B (rocking pattern, low priority).
//  The block arbitrates between them, clamps the requested duty and ramps the
//  duty output toward the target. Duty changes only on PWM period boundaries.
//  Its duty output drives the generator's 16-bit Invoer.
// PARAMETERS
//  PERIOD    24000  PWM period in CLK cycles; internal boundary counter length
//  DUTY_W    16     width of all duty values
//  MAX_DUTY  24000  upper clamp for the accepted target
//  STEP      100    maximum duty change per period (soft ramp)
// PORTS
//  CLK        in   1       clock, rising edge
//  resetmore  in   1       reset, asynchronous, active-high
//  halt       in   1       emergency stop, level
//  req_a      in   1       requester A valid (high priority)
//  duty_a     in   DUTY_W  requester A target duty
//  ack_a      out  1       1-cycle pulse: A request accepted
//  req_b      in   1       requester B valid (low priority)
//  duty_b     in   DUTY_W  requester B target duty
//  ack_b      out  1       1-cycle pulse: B request accepted
//  duty       out  DUTY_W  current duty -> PWM generator Invoer
//  busy       out  1       1 while in RAMP
//  done       out  1       1-cycle pulse: duty reached target
// BEHAVIOUR
//  Reset: cnt=0, duty=0, target=0, state=IDLE; ack_a, ack_b, busy, done = 0.
//  Period counter: cnt counts 0..PERIOD-1 and wraps. tick=1 when cnt==PERIOD-1.
//  Handshake: req is a level. Accept registers target=min(duty_x,MAX_DUTY) and
//   pulses ack_x in the next cycle. A req still high the cycle after its ack
//   is a new request.
//  Arbitration:
//   - IDLE: A wins over B. B stays un-acked and is taken on a later cycle.
//   - RAMP: A is accepted and preempts, replacing target. The ramp continues
//     from the current duty. B is held until IDLE.
//  FSM IDLE -> RAMP on accept with new target != duty.
//   - Accept with target == duty: stay IDLE, done pulses 1 cycle after ack.
//  RAMP, on each tick:
//   - duty<target: duty = min(duty+STEP, target).
//   - duty>target: duty = max(duty-STEP, target).
//   - Arithmetic in DUTY_W+1 bits, so there is no wrap at 0 or at 2^DUTY_W-1.
//   - When duty==target after the step: -> IDLE, done=1 for 1 cycle.
//  Accept and tick in the same cycle: no step on that tick. The first step
//   toward the new target is at the next tick.
//  busy = (state==RAMP), registered.
//  halt=1 (priority over everything):
//   - Next cycle duty=0, target=0, state=IDLE. No acks, no done.
//   - cnt keeps running.
//   - Requests pending at halt release are arbitrated normally.
//  resetmore mid-ramp: all state returns to reset values at once.
// CONFIGURATION
//  SOFT_RAMP_EN defined: ramp stepping by STEP per tick, as above.
//  SOFT_RAMP_EN undefined: duty=target at the first tick after accept. done
//   pulses in the same cycle as that update. busy is high from accept until then.
//   All other rules, including the same-cycle accept/tick rule, are unchanged.
// TESTING (defaults, SOFT_RAMP_EN defined unless noted)
//  1. Reset, req_b=1 duty_b=1000:
//     ack_b pulses; duty 100 after 1st tick, 1000 after 10th; done pulses; busy=0.
//  2. req_a=1 duty_a=500 and req_b=1 duty_b=2000 in the same IDLE cycle:
//     ack_a only. After duty=500 and done, ack_b; ramp to 2000 (15 ticks).
//  3. Ramping 0->3000, duty=1200, req_a duty_a=700:
//     ack_a; duty 1100,1000,...,700; done once; B never acked meanwhile.
//  4. req_b duty_b=30000 (>MAX_DUTY): target clamped; duty ends at 24000, never above.
//  5. Duty at 150, req_a duty_a=0:
//     duty 50 then 0 (no underflow); done. Then halt mid-ramp: duty=0 next cycle.
//  6. SOFT_RAMP_EN undefined, req_b duty_b=5000:
//     duty jumps 0->5000 at first tick after accept; done in that cycle.

Source files
------------

// File: rtl/pwm_duty_sequencer.sv
// Duty sequencer for the PWM generator: arbitrates two requesters, clamps, ramps on period ticks.
// Define SOFT_RAMP_EN for STEP-per-tick ramping; otherwise duty jumps to target at the first tick.
module pwm_duty_sequencer #(
  parameter int PERIOD   = 24000,
  parameter int DUTY_W   = 16,
  parameter int MAX_DUTY = 24000,
  parameter int STEP     = 100
) (
  input  logic              CLK,
  input  logic              resetmore,
  input  logic              halt,
  input  logic              req_a,
  input  logic [DUTY_W-1:0] duty_a,
  output logic              ack_a,
  input  logic              req_b,
  input  logic [DUTY_W-1:0] duty_b,
  output logic              ack_b,
  output logic [DUTY_W-1:0] duty,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RAMP = 1'b1;

  localparam logic [DUTY_W:0] MAX_X  = (DUTY_W+1)'(MAX_DUTY);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic [0:0]        state_q,  state_d;
  logic [DUTY_W-1:0] duty_q,   duty_d;
  logic [DUTY_W-1:0] tgt_q,    tgt_d;
  logic              ack_a_q,  ack_a_d;
  logic              ack_b_q,  ack_b_d;
  logic              done_q,   done_d;
  logic              busy_q,   busy_d;
  logic              pend_q,   pend_d;

  logic              tick;
  logic              take_a;
  logic              take_b;
  logic [DUTY_W-1:0] req_sel;
  logic [DUTY_W-1:0] clamp_v;
  logic [DUTY_W-1:0] step_v;

`ifdef SOFT_RAMP_EN
  localparam logic [DUTY_W:0] STEP_X = (DUTY_W+1)'(STEP);

  logic [DUTY_W:0]   up_x;
  logic [DUTY_W:0]   dn_lim;
  logic [DUTY_W-1:0] up_v;
  logic [DUTY_W-1:0] dn_v;

  // One extra bit keeps the sums honest near 0 and the top of range
  always_comb begin
    up_x   = {1'b0, duty_q} + STEP_X;
    dn_lim = {1'b0, tgt_q} + STEP_X;
    up_v   = (up_x > {1'b0, tgt_q}) ? tgt_q : up_x[DUTY_W-1:0];
    dn_v   = ({1'b0, duty_q} < dn_lim) ? tgt_q
           : duty_q - STEP_X[DUTY_W-1:0];
    step_v = (duty_q < tgt_q) ? up_v : dn_v;
  end
`else
  always_comb begin
    step_v = tgt_q;
  end
`endif

  always_comb begin
    tick    = (cnt_q == CNT_LAST);
    cnt_d   = tick ? '0 : cnt_q + 1'b1;
    take_a  = req_a & ~ack_a_q;
    take_b  = req_b & ~ack_b_q & ~take_a
            & (state_q == S_IDLE);
    req_sel = take_a ? duty_a : duty_b;
    clamp_v = ({1'b0, req_sel} > MAX_X)
            ? MAX_X[DUTY_W-1:0] : req_sel;
  end

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    tgt_d   = tgt_q;
    ack_a_d = 1'b0;
    ack_b_d = 1'b0;
    done_d  = pend_q;
    pend_d  = 1'b0;
    if (halt) begin
      state_d = S_IDLE;
      duty_d  = '0;
      tgt_d   = '0;
      done_d  = 1'b0;
    end else if (take_a | take_b) begin
      // An accept swallows a coincident tick
      tgt_d   = clamp_v;
      ack_a_d = take_a;
      ack_b_d = take_b;
      if (clamp_v == duty_q) begin
        state_d = S_IDLE;
        pend_d  = 1'b1;
      end else begin
        state_d = S_RAMP;
      end
    end else if ((state_q == S_RAMP) && tick) begin
      duty_d = step_v;
      if (step_v == tgt_q) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
    end
    busy_d = (state_d == S_RAMP);
  end

  always_ff @(posedge CLK or posedge resetmore) begin
    if (resetmore) begin
      cnt_q   <= '0;
      state_q <= S_IDLE;
      duty_q  <= '0;
      tgt_q   <= '0;
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      duty_q  <= duty_d;
      tgt_q   <= tgt_d;
      ack_a_q <= ack_a_d;
      ack_b_q <= ack_b_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      pend_q  <= pend_d;
    end
  end

  assign ack_a = ack_a_q;
  assign ack_b = ack_b_q;
  assign duty  = duty_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Bench for pwm_duty_sequencer: event scoreboard fed by a per-edge reference model.
// Works with or without SOFT_RAMP_EN; uses a short PERIOD to keep runs brief.
module tb_pwm_duty_sequencer;

  localparam int PERIOD   = 20;
  localparam int DUTY_W   = 16;
  localparam int MAX_DUTY = 24000;
  localparam int STEP     = 100;
  localparam int LIM      = 400 * PERIOD;

`ifdef SOFT_RAMP_EN
  localparam bit SOFT = 1'b1;
`else
  localparam bit SOFT = 1'b0;
`endif

  localparam int K_DUTY = 0;
  localparam int K_BUSY = 1;
  localparam int K_ACKA = 2;
  localparam int K_ACKB = 3;
  localparam int K_DONE = 4;

  logic              CLK = 1'b0;
  logic              resetmore = 1'b1;
  logic              halt = 1'b0;
  logic              req_a = 1'b0;
  logic              req_b = 1'b0;
  logic [DUTY_W-1:0] duty_a = '0;
  logic [DUTY_W-1:0] duty_b = '0;
  logic              ack_a, ack_b, busy, done;
  logic [DUTY_W-1:0] duty;

  always #5 CLK = ~CLK;

  pwm_duty_sequencer #(
    .PERIOD(PERIOD), .DUTY_W(DUTY_W),
    .MAX_DUTY(MAX_DUTY), .STEP(STEP)
  ) dut (
    .CLK(CLK), .resetmore(resetmore), .halt(halt),
    .req_a(req_a), .duty_a(duty_a), .ack_a(ack_a),
    .req_b(req_b), .duty_b(duty_b), .ack_b(ack_b),
    .duty(duty), .busy(busy), .done(done)
  );

  typedef struct {
    int kind;
    int val;
    int cyc;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;

  int m_cnt = 0, m_duty = 0, m_tgt = 0;
  bit m_ramp = 0, m_acka = 0, m_ackb = 0, m_pend = 0;

  function automatic string kname(int k);
    case (k)
      K_DUTY:  return "duty";
      K_BUSY:  return "busy";
      K_ACKA:  return "ack_a";
      K_ACKB:  return "ack_b";
      default: return "done";
    endcase
  endfunction

  function automatic void push(int k, int v);
    ev_t e;
    e.kind = k; e.val = v; e.cyc = cyc;
    exp_q.push_back(e);
  endfunction

  // Reference model: what each requester/tick rule implies at this edge
  initial begin
    int od, tv;
    bit orr, na, nb, nd, tk, ta, tb;
    forever begin
      @(posedge CLK);
      cyc++;
      if (resetmore) begin
        m_cnt = 0; m_duty = 0; m_tgt = 0;
        m_ramp = 0; m_acka = 0; m_ackb = 0; m_pend = 0;
      end else begin
        od = m_duty; orr = m_ramp;
        na = 0; nb = 0;
        tk = (m_cnt == PERIOD - 1);
        m_cnt = tk ? 0 : m_cnt + 1;
        nd = m_pend; m_pend = 0;
        if (halt) begin
          m_duty = 0; m_tgt = 0; m_ramp = 0; nd = 0;
        end else begin
          ta = req_a && !m_acka;
          tb = !ta && req_b && !m_ackb && !m_ramp;
          if (ta || tb) begin
            tv = ta ? int'(duty_a) : int'(duty_b);
            m_tgt = (tv > MAX_DUTY) ? MAX_DUTY : tv;
            na = ta; nb = tb;
            m_ramp = (m_tgt != m_duty);
            m_pend = !m_ramp;
          end else if (m_ramp && tk) begin
            if (!SOFT) m_duty = m_tgt;
            else if (m_duty < m_tgt)
              m_duty = (m_duty + STEP > m_tgt) ? m_tgt : m_duty + STEP;
            else
              m_duty = (m_duty - STEP < m_tgt) ? m_tgt : m_duty - STEP;
            if (m_duty == m_tgt) begin
              m_ramp = 0; nd = 1;
            end
          end
        end
        m_acka = na; m_ackb = nb;
        if (m_duty != od) push(K_DUTY, m_duty);
        if (m_ramp != orr) push(K_BUSY, int'(m_ramp));
        if (na) push(K_ACKA, 0);
        if (nb) push(K_ACKB, 0);
        if (nd) push(K_DONE, 0);
      end
    end
  end

  task automatic chk_ev(int k, int v);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: got %0d at cyc %0d, expected no event",
               kname(k), v, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.val != v || e.cyc != cyc) begin
        errors++;
        $display("FAIL %s: got %0d at cyc %0d, expected %s=%0d at cyc %0d",
                 kname(k), v, cyc, kname(e.kind), e.val, e.cyc);
      end
    end
  endtask

  // Monitor: every visible output change must match the next queued event
  initial begin
    int last_duty = 0;
    bit last_busy = 0;
    ev_t e;
    forever begin
      @(negedge CLK);
      if (resetmore) begin
        exp_q.delete();
        last_duty = 0; last_busy = 0;
        checks++;
        if ({duty, busy, ack_a, ack_b, done} != '0) begin
          errors++;
          $display("FAIL reset_outputs: got duty=%0d busy=%b acks=%b%b done=%b, expected all 0",
                   duty, busy, ack_a, ack_b, done);
        end
      end else begin
        if (int'(duty) != last_duty) begin
          chk_ev(K_DUTY, int'(duty)); last_duty = int'(duty);
        end
        if (busy != last_busy) begin
          chk_ev(K_BUSY, int'(busy)); last_busy = busy;
        end
        if (ack_a) chk_ev(K_ACKA, 0);
        if (ack_b) chk_ev(K_ACKB, 0);
        if (done)  chk_ev(K_DONE, 0);
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
          e = exp_q.pop_front();
          checks++; errors++;
          $display("FAIL missing_%s: expected %0d at cyc %0d, got nothing",
                   kname(e.kind), e.val, e.cyc);
        end
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk_val(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout(string name);
    errors++;
    $display("FAIL %s: timed out, got no response, expected one within %0d cycles",
             name, LIM);
  endtask

  task automatic request(bit is_a, int v);
    bit ok = 0;
    if (is_a) begin req_a = 1; duty_a = DUTY_W'(v); end
    else      begin req_b = 1; duty_b = DUTY_W'(v); end
    checks++;
    for (int i = 0; i < LIM; i++) begin
      step(1);
      if (is_a ? ack_a : ack_b) begin ok = 1; break; end
    end
    if (is_a) req_a = 0; else req_b = 0;
    if (!ok) timeout(is_a ? "ack_a_wait" : "ack_b_wait");
  endtask

  task automatic wait_idle();
    bit ok = 0;
    checks++;
    for (int i = 0; i < LIM; i++) begin
      step(1);
      if (!busy && !ack_a && !ack_b && !done && !m_pend
          && !req_a && !req_b) begin
        ok = 1; break;
      end
    end
    if (!ok) timeout("idle_wait");
  endtask

  task automatic both(int va, int vb);
    bit ok = 0;
    req_a = 1; duty_a = DUTY_W'(va);
    req_b = 1; duty_b = DUTY_W'(vb);
    checks++;
    for (int i = 0; i < LIM; i++) begin
      step(1);
      if (ack_a) req_a = 0;
      if (ack_b) req_b = 0;
      if (!req_a && !req_b) begin ok = 1; break; end
    end
    req_a = 0; req_b = 0;
    if (!ok) timeout("dual_ack_wait");
  endtask

  function automatic int pick();
    int r = $urandom_range(0, 9);
    if (r == 0) return m_duty;
    if (r == 1) return MAX_DUTY + $urandom_range(0, 41535);
    return $urandom_range(0, 2000);
  endfunction

  initial begin
    bit ok;
    step(3);
    resetmore = 0;

    request(0, 1000);
    wait_idle();
    chk_val("t1_duty", int'(duty), 1000);
    chk_val("t1_busy", int'(busy), 0);

    both(500, 2000);
    wait_idle();
    chk_val("t2_duty", int'(duty), 2000);

    halt = 1; step(1); halt = 0;
    chk_val("t3_halt_duty", int'(duty), 0);
    request(0, 3000);
    ok = 0;
    for (int i = 0; i < LIM; i++) begin
      step(1);
      if (duty >= 1200 || !busy) begin ok = 1; break; end
    end
    checks++;
    if (!ok) timeout("t3_reach_1200");
    both(700, 4000);
    wait_idle();
    chk_val("t3_duty", int'(duty), 4000);

    request(0, 30000);
    wait_idle();
    chk_val("t4_clamp", int'(duty), MAX_DUTY);

    request(1, 150);
    wait_idle();
    chk_val("t5_duty150", int'(duty), 150);
    request(1, 0);
    wait_idle();
    chk_val("t5_duty0", int'(duty), 0);

    request(0, 5000);
    step(3 * PERIOD + 3);
    halt = 1; step(1);
    chk_val("t5_halt_duty", int'(duty), 0);
    chk_val("t5_halt_busy", int'(busy), 0);
    req_b = 1; duty_b = 16'd800;
    step(2);
    halt = 0;
    request(0, 800);
    wait_idle();
    chk_val("t5_after_halt", int'(duty), 800);

    request(1, 3000);
    step(2 * PERIOD);
    #2 resetmore = 1;
    #1;
    chk_val("rst_async_duty", int'(duty), 0);
    chk_val("rst_async_busy", int'(busy), 0);
    @(posedge CLK); #1 resetmore = 0;

    for (int i = 0; i < 4000; i++) begin
      step(1);
      if (ack_a) req_a = 0;
      if (ack_b) req_b = 0;
      if (!req_a && $urandom_range(0, 29) == 0) begin
        req_a = 1; duty_a = DUTY_W'(pick());
      end
      if (!req_b && $urandom_range(0, 19) == 0) begin
        req_b = 1; duty_b = DUTY_W'(pick());
      end
      halt = ($urandom_range(0, 199) == 0);
    end
    halt = 0;
    ok = 0;
    for (int i = 0; i < LIM; i++) begin
      step(1);
      if (ack_a) req_a = 0;
      if (ack_b) req_b = 0;
      if (!req_a && !req_b) begin ok = 1; break; end
    end
    checks++;
    if (!ok) timeout("rand_drain");
    req_a = 0; req_b = 0;
    wait_idle();
    step(3);
    chk_val("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
